sccb_slave_responder: RTL and testbench
=======================================

Name: sccb_slave_responder

Overview:
- SCCB slave (responder) end of the protocol driven by the team's SCCB master controller.
- Oversamples SIO_C/SIO_D with the system clock, detects START/STOP, and decodes 2-phase write, 3-phase write and 2-phase read transactions addressed to its device ID.
- Delivers write bytes to a register-file client over a valid/ready stream.
- Serves read bytes from a combinational register-file lookup.
- Used as a camera-sensor model in verification and as a real slave port in bridge designs.

Parameters:
- DATA_W, 8: byte width on the bus (sub-address, data, device address + R/W bit).
- SYNC_STAGES, 2: synchronizer flops on sio_c_i and sio_d (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the SIO_C frequency.
- rst_n  in  1  asynchronous active-low reset.
- slv_dvc_addr_i  in  DATA_W-1  own 7-bit device address; quasi-static.
- sio_c_i  in  1  SCCB clock from master.
- sio_d  inout  1  SCCB data; driven only when sio_oe internal is 1, else 'z'.
- wr_sub_adr_o  out  DATA_W  sub-address of completed 3-phase write.
- wr_data_o  out  DATA_W  data byte of completed 3-phase write.
- wr_vld_o  out  1  write stream valid.
- wr_rdy_i  in  1  write stream ready.
- wr_drop_o  out  1  one-clk pulse: pending write overwritten before acceptance.
- rd_adr_o  out  DATA_W  current sub-address register (read pointer).
- rd_data_i  in  DATA_W  register-file data for rd_adr_o, combinational.
- busy_o  out  1  high from START to STOP/abort.

Behaviour:
- Reset: state IDLE, sio_d released, wr_vld_o=0, wr_drop_o=0, busy_o=0, wr_sub_adr_o=0, wr_data_o=0, rd_adr_o=0. Reset mid-transaction releases sio_d immediately (async).
- Front end: SYNC_STAGES flops plus one edge-detect flop per line. Bus events are visible SYNC_STAGES+1 clk after the pin change.
- START: SIO_D falls while SIO_C is high. Accepted in any state. Enter DEV_ADDR, set busy_o, clear bit counter.
- STOP: SIO_D rises while SIO_C is high. Accepted in any state. Go to IDLE, release sio_d, clear busy_o.
- Sampling and driving: SIO_D is sampled on the SIO_C rising edge, MSB first. The slave drives new values on the SIO_C falling edge.
- Bit counter: 3 bits. On the falling edge after the 8th rising edge, move to the ACK state of the phase.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. Byte[7:1] != slv_dvc_addr_i goes to WAIT_STOP after the 8th bit; a match goes to DEV_ACK.
  - DEV_ACK (9th bit, don't-care): if byte[0]=0 (write), next is SUB_ADDR. If byte[0]=1 (read), next is RD_DATA: load shifter with rd_data_i and drive bit 7 on the falling edge ending the ACK.
  - SUB_ADDR: shift 8 bits, then SUB_ACK. On entering SUB_ACK, rd_adr_o <= received byte.
  - SUB_ACK: next is WR_DATA. A STOP here completes a 2-phase write: rd_adr_o is updated and there is no stream output.
  - WR_DATA: shift 8 bits. Then wr_sub_adr_o <= rd_adr_o, wr_data_o <= byte, wr_vld_o <= 1 one clk after the 8th sample. Next state is WR_ACK.
  - WR_ACK: then WAIT_STOP. Additional bytes are ignored; there is no auto-increment.
  - RD_DATA: drive 8 bits, shifting on each falling edge. Release sio_d on the falling edge after bit 0, then RD_NA.
  - RD_NA: master NA bit, ignored. Then WAIT_STOP.
  - WAIT_STOP: sio_d released; wait for STOP or START.
- Write stream: wr_vld_o is held until wr_vld_o&wr_rdy_i, then cleared next clk. Outputs are stable while valid. If a new write completes while wr_vld_o is still 1, the payload is overwritten, wr_vld_o stays 1, and wr_drop_o pulses for 1 clk.
- Handshake and completion in the same clk: the handshake consumes the old payload, the new payload loads, wr_vld_o stays 1, and there is no drop.
- Repeated START mid-byte: counter and shifter cleared, sio_d released, restart in DEV_ADDR.
- SIO_C glitches shorter than SYNC_STAGES clk are not guaranteed to be filtered.

Optional Feature:
- Macro SCCB_SLV_ACK_DRIVE_EN.
- Defined: the slave drives sio_d=0 during DEV_ACK (on address match only), SUB_ACK and WR_ACK. It drives from the falling edge that starts the ACK bit and releases on the falling edge that ends it. This gives I2C-compatible acknowledgement.
- Undefined: sio_d stays released in all ACK bits (pure SCCB don't-care bit). Everything else is identical.

Decomposition:
- Shared package sccb_pkg: state encoding localparams (IDLE..WAIT_STOP), DATA_W default, R/W bit polarity constant (1=read on wire).
- Sub-module sccb_line_sync: synchronizer plus edge detect. Outputs scl_rise, scl_fall, sda_level, start_det, stop_det. The same sub-module is reusable by the master for clock stretching.

Test Plan:
- Addr 7'h21, 3-phase write 0x42 / sub 0x12 / data 0xA5, wr_rdy_i=1 -> wr_vld_o one pulse with wr_sub_adr_o=0x12, wr_data_o=0xA5. sio_d never driven when macro undefined.
- 2-phase write sub 0x30, then 2-phase read 0x43, register file returns 0x5C at address 0x30 -> rd_adr_o=0x30, master samples 0x5C MSB first, sio_d released after bit 0.
- Address 0x44 (7'h22, mismatch) with following bytes -> no drive, no wr_vld_o, busy_o high until STOP.
- wr_rdy_i=0 across two 3-phase writes (0x01/0x11, 0x02/0x22) -> wr_drop_o one pulse, wr_vld_o holds 0x02/0x22.
- Repeated START after 4 bits of sub-address, then a full write -> first transaction aborted, second delivered. rst_n asserted during RD_DATA -> sio_d 'z' in the same clk as reset assertion.
- SCCB_SLV_ACK_DRIVE_EN defined, 3-phase write -> sio_d=0 during all three ACK bits. No drive during ACK on address mismatch.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, default byte width and
// the read/write bit polarity as it appears on the wire.
package sccb_pkg;

   localparam int unsigned SCCB_DATA_W = 8;

   // Value of the LSB of the device-address byte that requests a read
   localparam logic SCCB_RW_READ = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_SUB_ADDR,
      ST_SUB_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_NA,
      ST_WAIT_STOP
   } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// SIO_C/SIO_D synchronizer with edge and START/STOP detection.
// Shared with the master side, which uses it for clock stretching.
module sccb_line_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_level,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   // Lines reset to the idle-high level so release of reset never looks like an event
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   assign scl_s     = scl_sync_q[SYNC_STAGES-1];
   assign sda_s     = sda_sync_q[SYNC_STAGES-1];
   assign sda_level = sda_s;
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/sccb_slave_responder.sv
// SCCB slave: decodes 2/3-phase writes and 2-phase reads for its device ID.
// Define SCCB_SLV_ACK_DRIVE_EN to drive sio_d low in ACK bits (I2C-style).
module sccb_slave_responder
   import sccb_pkg::*;
#(
   parameter int unsigned DATA_W      = SCCB_DATA_W,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-2:0] slv_dvc_addr_i,
   input  logic              sio_c_i,
   inout  wire               sio_d,
   output logic [DATA_W-1:0] wr_sub_adr_o,
   output logic [DATA_W-1:0] wr_data_o,
   output logic              wr_vld_o,
   input  logic              wr_rdy_i,
   output logic              wr_drop_o,
   output logic [DATA_W-1:0] rd_adr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              busy_o
);

`ifdef SCCB_SLV_ACK_DRIVE_EN
   localparam logic ACK_DRIVE = 1'b1;
`else
   localparam logic ACK_DRIVE = 1'b0;
`endif

   logic scl_rise, scl_fall, sda_level, start_det, stop_det;

   sccb_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (sio_c_i),
      .sda_i     (sio_d),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_level (sda_level),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   sccb_state_e       state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              full_q, full_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              oe_q, oe_d;
   logic              sdo_q, sdo_d;
   logic [DATA_W-1:0] rd_adr_q, rd_adr_d;
   logic [DATA_W-1:0] wr_sub_q, wr_sub_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wr_vld_q, wr_vld_d;
   logic              wr_drop_q, wr_drop_d;
   logic              wr_load;
   logic [DATA_W-1:0] rx_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         full_q    <= 1'b0;
         shift_q   <= '0;
         oe_q      <= 1'b0;
         sdo_q     <= 1'b0;
         rd_adr_q  <= '0;
         wr_sub_q  <= '0;
         wr_data_q <= '0;
         wr_vld_q  <= 1'b0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         full_q    <= full_d;
         shift_q   <= shift_d;
         oe_q      <= oe_d;
         sdo_q     <= sdo_d;
         rd_adr_q  <= rd_adr_d;
         wr_sub_q  <= wr_sub_d;
         wr_data_q <= wr_data_d;
         wr_vld_q  <= wr_vld_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   assign rx_byte = {shift_q[DATA_W-2:0], sda_level};

   // full_q marks "8 bits sampled"; the following falling edge moves into the ACK bit
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      full_d   = full_q;
      shift_d  = shift_q;
      oe_d     = oe_q;
      sdo_d    = sdo_q;
      rd_adr_d = rd_adr_q;
      wr_load  = 1'b0;

      if (start_det) begin
         state_d = ST_DEV_ADDR;
         cnt_d   = '0;
         full_d  = 1'b0;
         shift_d = '0;
         oe_d    = 1'b0;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_DEV_ADDR, ST_SUB_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = rx_byte;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     full_d  = 1'b1;
                     wr_load = (state_q == ST_WR_DATA);
                  end
               end else if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  cnt_d  = '0;
                  sdo_d  = 1'b0;
                  if (state_q == ST_DEV_ADDR) begin
                     if (shift_q[DATA_W-1:1] == slv_dvc_addr_i) begin
                        state_d = ST_DEV_ACK;
                        oe_d    = ACK_DRIVE;
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end else if (state_q == ST_SUB_ADDR) begin
                     state_d  = ST_SUB_ACK;
                     rd_adr_d = shift_q;
                     oe_d     = ACK_DRIVE;
                  end else begin
                     state_d = ST_WR_ACK;
                     oe_d    = ACK_DRIVE;
                  end
               end
            end
            ST_DEV_ACK: begin
               if (scl_fall) begin
                  cnt_d = '0;
                  if (shift_q[0] == SCCB_RW_READ) begin
                     state_d = ST_RD_DATA;
                     shift_d = rd_data_i;
                     sdo_d   = rd_data_i[DATA_W-1];
                     oe_d    = 1'b1;
                  end else begin
                     state_d = ST_SUB_ADDR;
                     oe_d    = 1'b0;
                  end
               end
            end
            ST_SUB_ACK: begin
               if (scl_fall) begin
                  state_d = ST_WR_DATA;
                  oe_d    = 1'b0;
               end
            end
            ST_WR_ACK: begin
               if (scl_fall) begin
                  state_d = ST_WAIT_STOP;
                  oe_d    = 1'b0;
               end
            end
            ST_RD_DATA: begin
               // cnt_q counts bits already driven after the MSB
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     state_d = ST_RD_NA;
                     oe_d    = 1'b0;
                  end else begin
                     shift_d = {shift_q[DATA_W-2:0], 1'b0};
                     sdo_d   = shift_q[DATA_W-2];
                     cnt_d   = cnt_q + 3'd1;
                  end
               end
            end
            ST_RD_NA: begin
               if (scl_fall) begin
                  state_d = ST_WAIT_STOP;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // A handshake in the same cycle as a new load consumes the old payload, so no drop
   always_comb begin
      wr_sub_d  = wr_sub_q;
      wr_data_d = wr_data_q;
      wr_vld_d  = wr_vld_q & ~wr_rdy_i;
      wr_drop_d = 1'b0;
      if (wr_load) begin
         wr_sub_d  = rd_adr_q;
         wr_data_d = rx_byte;
         wr_vld_d  = 1'b1;
         wr_drop_d = wr_vld_q & ~wr_rdy_i;
      end
   end

   assign sio_d        = oe_q ? sdo_q : 1'bz;
   assign wr_sub_adr_o = wr_sub_q;
   assign wr_data_o    = wr_data_q;
   assign wr_vld_o     = wr_vld_q;
   assign wr_drop_o    = wr_drop_q;
   assign rd_adr_o     = rd_adr_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Directed bench acting as SCCB master plus a register-file model.
module tb_sccb_slave_responder;

`ifdef SCCB_SLV_ACK_DRIVE_EN
   localparam logic ACK_EXP = 1'b0;
`else
   localparam logic ACK_EXP = 1'b1;
`endif
   localparam int Q = 8;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       scl    = 1'b1;
   logic       m_oe   = 1'b0;
   logic       m_val  = 1'b1;
   logic       wr_rdy = 1'b1;
   logic [6:0] dev_addr = 7'h21;
   logic [7:0] wr_sub, wr_data, rd_adr, rd_data;
   logic       wr_vld, wr_drop, busy;
   wire        sio_d;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   acc_cnt  = 0;
   int   drop_cnt = 0;
   logic [7:0] acc_sub  = '0;
   logic [7:0] acc_data = '0;
   logic       a;
   logic [7:0] rb;

   assign sio_d = m_oe ? m_val : 1'bz;
   pullup (sio_d);
   assign rd_data = (rd_adr == 8'h30) ? 8'h5C : 8'h3C;

   always #5 clk = ~clk;

   sccb_slave_responder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .slv_dvc_addr_i (dev_addr),
      .sio_c_i        (scl),
      .sio_d          (sio_d),
      .wr_sub_adr_o   (wr_sub),
      .wr_data_o      (wr_data),
      .wr_vld_o       (wr_vld),
      .wr_rdy_i       (wr_rdy),
      .wr_drop_o      (wr_drop),
      .rd_adr_o       (rd_adr),
      .rd_data_i      (rd_data),
      .busy_o         (busy)
   );

   always @(negedge clk) begin
      if (wr_vld && wr_rdy) begin
         acc_cnt++;
         acc_sub  = wr_sub;
         acc_data = wr_data;
      end
      if (wr_drop) drop_cnt++;
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_start();
      m_oe = 1'b1; m_val = 1'b1; wclk(Q);
      scl = 1'b1; wclk(Q);
      m_val = 1'b0; wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic bus_stop();
      scl = 1'b0; m_oe = 1'b1; m_val = 1'b0; wclk(Q);
      scl = 1'b1; wclk(Q);
      m_val = 1'b1; wclk(2*Q);
   endtask

   task automatic send_bit(input logic b);
      m_oe = 1'b1; m_val = b; wclk(Q);
      scl = 1'b1; wclk(2*Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic recv_bit(output logic b);
      m_oe = 1'b0; wclk(Q);
      scl = 1'b1; wclk(Q);
      b = sio_d; wclk(Q);
      scl = 1'b0; wclk(Q);
   endtask

   task automatic recv_byte(output logic [7:0] b);
      logic x;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(x);
         b[i] = x;
      end
   endtask

   initial begin
      // Reset state
      wclk(3);
      check("rst_vld", wr_vld, 0);
      check("rst_drop", wr_drop, 0);
      check("rst_busy", busy, 0);
      check("rst_sub", wr_sub, 0);
      check("rst_data", wr_data, 0);
      check("rst_rdadr", rd_adr, 0);
      check("rst_sio", sio_d, 1);
      rst_n = 1'b1; wclk(4);

      // 3-phase write 0x42 / 0x12 / 0xA5
      bus_start();
      check("w3_busy", busy, 1);
      send_byte(8'h42); recv_bit(a); check("w3_devack", a, ACK_EXP);
      send_byte(8'h12); recv_bit(a); check("w3_suback", a, ACK_EXP);
      send_byte(8'hA5); recv_bit(a); check("w3_wrack", a, ACK_EXP);
      bus_stop();
      check("w3_busy_end", busy, 0);
      check("w3_acc_cnt", acc_cnt, 1);
      check("w3_sub", acc_sub, 8'h12);
      check("w3_data", acc_data, 8'hA5);
      check("w3_vld_clr", wr_vld, 0);
      check("w3_rdadr", rd_adr, 8'h12);

      // 2-phase write of sub-address 0x30, then 2-phase read
      bus_start();
      send_byte(8'h42); recv_bit(a);
      send_byte(8'h30); recv_bit(a);
      bus_stop();
      check("w2_rdadr", rd_adr, 8'h30);
      check("w2_no_stream", acc_cnt, 1);
      bus_start();
      send_byte(8'h43); recv_bit(a); check("rd_devack", a, ACK_EXP);
      recv_byte(rb);
      check("rd_byte", rb, 8'h5C);
      recv_bit(a); check("rd_release", a, 1);
      bus_stop();
      check("rd_rdadr", rd_adr, 8'h30);
      check("rd_busy_end", busy, 0);

      // Address mismatch
      bus_start();
      send_byte(8'h44); recv_bit(a); check("mm_ack0", a, 1);
      send_byte(8'h12); recv_bit(a); check("mm_ack1", a, 1);
      send_byte(8'hA5); recv_bit(a); check("mm_ack2", a, 1);
      check("mm_busy", busy, 1);
      bus_stop();
      check("mm_busy_end", busy, 0);
      check("mm_no_stream", acc_cnt, 1);
      check("mm_vld", wr_vld, 0);

      // Back-pressure: second write overwrites pending payload
      wr_rdy = 1'b0;
      bus_start();
      send_byte(8'h42); recv_bit(a); send_byte(8'h01); recv_bit(a);
      send_byte(8'h11); recv_bit(a);
      bus_stop();
      check("bp_vld1", wr_vld, 1);
      check("bp_sub1", wr_sub, 8'h01);
      check("bp_data1", wr_data, 8'h11);
      check("bp_nodrop", drop_cnt, 0);
      bus_start();
      send_byte(8'h42); recv_bit(a); send_byte(8'h02); recv_bit(a);
      send_byte(8'h22); recv_bit(a);
      bus_stop();
      check("bp_drop", drop_cnt, 1);
      check("bp_vld2", wr_vld, 1);
      check("bp_sub2", wr_sub, 8'h02);
      check("bp_data2", wr_data, 8'h22);
      wr_rdy = 1'b1; wclk(3);
      check("bp_acc_cnt", acc_cnt, 2);
      check("bp_acc_sub", acc_sub, 8'h02);
      check("bp_acc_data", acc_data, 8'h22);
      check("bp_vld_clr", wr_vld, 0);

      // Repeated START after 4 sub-address bits, then full write
      bus_start();
      send_byte(8'h42); recv_bit(a);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      bus_start();
      send_byte(8'h42); recv_bit(a); send_byte(8'h66); recv_bit(a);
      send_byte(8'h99); recv_bit(a);
      bus_stop();
      check("rs_acc_cnt", acc_cnt, 3);
      check("rs_sub", acc_sub, 8'h66);
      check("rs_data", acc_data, 8'h99);
      check("rs_rdadr", rd_adr, 8'h66);
      check("rs_drop", drop_cnt, 1);

      // Reset asserted while the slave drives read data (MSB of 0x3C is 0)
      bus_start();
      send_byte(8'h43); recv_bit(a);
      m_oe = 1'b0; wclk(Q);
      scl = 1'b1; wclk(Q);
      check("rr_drive", sio_d, 0);
      rst_n = 1'b0; #1;
      check("rr_release", sio_d, 1);
      check("rr_busy", busy, 0);
      check("rr_rdadr", rd_adr, 0);
      wclk(2);
      scl = 1'b0; wclk(Q);
      rst_n = 1'b1; wclk(Q);
      bus_stop();
      check("rr_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
